// File: rtl/idu_decode.sv
// RV32I decode stage: accepts {inst, pc} fetch packets, decodes one instruction per
// transfer and holds the registered control/operand bundle for the execute stage.
module idu_decode #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ifu_valid,
  input  logic [2*WIDTH-1:0] ifu_data,
  output logic               idu_ready,
  input  logic               flush,
  output logic               idu_valid,
  input  logic               exu_ready,
  output logic [WIDTH-1:0]   dec_pc,
  output logic [4:0]         dec_rd,
  output logic [4:0]         dec_rs1,
  output logic [4:0]         dec_rs2,
  output logic [WIDTH-1:0]   dec_imm,
  output logic [2:0]         dec_funct3,
  output logic [3:0]         dec_alu_op,
  output logic               dec_alu_src_imm,
  output logic               dec_wen,
  output logic               dec_mem_ren,
  output logic               dec_mem_wen,
  output logic               dec_branch,
  output logic               dec_jal,
  output logic               dec_jalr,
  output logic               dec_lui,
  output logic               dec_auipc,
  output logic               dec_ebreak,
  output logic               dec_illegal
);

  localparam int unsigned REG_W    = 5;
  localparam int unsigned ALU_W    = 4;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned OPCODE_W = 7;

  localparam logic [OPCODE_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPCODE_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPCODE_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPCODE_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPCODE_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPCODE_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPCODE_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPCODE_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPCODE_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPCODE_W-1:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [WIDTH-1:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [ALU_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5
  } imm_fmt_e;

  typedef struct packed {
    logic [WIDTH-1:0] pc;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [WIDTH-1:0] imm;
    logic [F3_W-1:0]  funct3;
    logic [ALU_W-1:0] alu_op;
    logic             alu_src_imm;
    logic             wen;
    logic             mem_ren;
    logic             mem_wen;
    logic             branch;
    logic             jal;
    logic             jalr;
    logic             lui;
    logic             auipc;
    logic             ebreak;
    logic             illegal;
  } dec_bundle_t;

  // Register-op ALU select; alt is funct7[5], allow_sub is 0 for immediate ops.
  function automatic logic [ALU_W-1:0] alu_from_funct3(input logic [F3_W-1:0] f3,
                                                      input logic alt,
                                                      input logic allow_sub);
    logic [ALU_W-1:0] op;
    case (f3)
      3'd0:    op = (alt && allow_sub) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [WIDTH-1:0]    inst;
  logic [WIDTH-1:0]    pc;
  logic [OPCODE_W-1:0] opcode;
  logic [F3_W-1:0]     funct3;
  logic [6:0]          funct7;
  logic [REG_W-1:0]    rd;

  imm_fmt_e         imm_fmt;
  logic [WIDTH-1:0] imm;
  logic [ALU_W-1:0] alu_op;
  logic             src_imm;
  logic             wr_class;
  logic             is_load;
  logic             is_store;
  logic             is_branch;
  logic             is_jal;
  logic             is_jalr;
  logic             is_lui;
  logic             is_auipc;
  logic             is_ebreak;
  logic             is_illegal;
  logic             kill;

  dec_bundle_t dec_bundle;
  dec_bundle_t bundle_d;
  dec_bundle_t bundle_q;
  logic        valid_d;
  logic        valid_q;
  logic        in_xfer;
  logic        out_xfer;

  assign inst   = ifu_data[2*WIDTH-1:WIDTH];
  assign pc     = ifu_data[WIDTH-1:0];
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];

  // Opcode classification, legality and ALU operation select.
  always_comb begin
    imm_fmt    = FMT_NONE;
    alu_op     = ALU_ADD;
    src_imm    = 1'b0;
    wr_class   = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    is_lui     = 1'b0;
    is_auipc   = 1'b0;
    is_ebreak  = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        wr_class   = 1'b1;
        alu_op     = alu_from_funct3(funct3, funct7[5], 1'b1);
        is_illegal = !((funct7 == 7'h00) ||
                       ((funct7 == 7'h20) && ((funct3 == 3'd0) || (funct3 == 3'd5))));
      end
      OPC_OP_IMM: begin
        wr_class = 1'b1;
        src_imm  = 1'b1;
        imm_fmt  = FMT_I;
        alu_op   = alu_from_funct3(funct3, funct7[5], 1'b0);
        if (funct3 == 3'd1) begin
          is_illegal = (funct7 != 7'h00);
        end else if (funct3 == 3'd5) begin
          is_illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
        end
      end
      OPC_LOAD: begin
        wr_class   = 1'b1;
        src_imm    = 1'b1;
        imm_fmt    = FMT_I;
        is_load    = 1'b1;
        is_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
      end
      OPC_STORE: begin
        src_imm    = 1'b1;
        imm_fmt    = FMT_S;
        is_store   = 1'b1;
        is_illegal = (funct3 >= 3'd3);
      end
      OPC_BRANCH: begin
        imm_fmt    = FMT_B;
        is_branch  = 1'b1;
        is_illegal = (funct3 == 3'd2) || (funct3 == 3'd3);
      end
      OPC_JAL: begin
        wr_class = 1'b1;
        src_imm  = 1'b1;
        imm_fmt  = FMT_J;
        is_jal   = 1'b1;
      end
      OPC_JALR: begin
        wr_class   = 1'b1;
        src_imm    = 1'b1;
        imm_fmt    = FMT_I;
        is_jalr    = 1'b1;
        is_illegal = (funct3 != 3'd0);
      end
      OPC_LUI: begin
        wr_class = 1'b1;
        src_imm  = 1'b1;
        imm_fmt  = FMT_U;
        is_lui   = 1'b1;
      end
      OPC_AUIPC: begin
        wr_class = 1'b1;
        src_imm  = 1'b1;
        imm_fmt  = FMT_U;
        is_auipc = 1'b1;
      end
      OPC_MISC_MEM: begin
        // FENCE retires as a no-op in this in-order pipeline.
        imm_fmt = FMT_I;
      end
      OPC_SYSTEM: begin
        imm_fmt    = FMT_I;
        is_ebreak  = (inst == INST_EBREAK);
        is_illegal = (inst != INST_EBREAK);
      end
      default: begin
        // Also catches inst[1:0] != 2'b11, since every known opcode ends in 2'b11.
        is_illegal = 1'b1;
      end
    endcase
  end

  // Immediate assembly by instruction format.
  always_comb begin
    imm = '0;
    case (imm_fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'b0};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

  // Assemble the decoded bundle; illegal and ebreak suppress all side effects.
  always_comb begin
    kill                   = is_illegal | is_ebreak;
    dec_bundle             = '0;
    dec_bundle.pc          = pc;
    dec_bundle.rd          = rd;
    dec_bundle.rs1         = inst[19:15];
    dec_bundle.rs2         = inst[24:20];
    dec_bundle.imm         = imm;
    dec_bundle.funct3      = funct3;
    dec_bundle.alu_op      = alu_op;
    dec_bundle.alu_src_imm = src_imm;
    dec_bundle.wen         = wr_class & (rd != 5'd0) & ~kill;
    dec_bundle.mem_ren     = is_load & ~kill;
    dec_bundle.mem_wen     = is_store & ~kill;
    dec_bundle.branch      = is_branch & ~kill;
    dec_bundle.jal         = is_jal & ~kill;
    dec_bundle.jalr        = is_jalr & ~kill;
    dec_bundle.lui         = is_lui;
    dec_bundle.auipc       = is_auipc;
    dec_bundle.ebreak      = is_ebreak;
    dec_bundle.illegal     = is_illegal;
  end

  // Ready while the slot is empty or draining; reset and flush both block acceptance.
  assign idu_ready = rst & ~flush & (~valid_q | exu_ready);
  assign in_xfer   = ifu_valid & idu_ready;
  assign out_xfer  = valid_q & exu_ready;

  // Output slot next state: flush beats load, load beats drain, otherwise hold.
  always_comb begin
    valid_d  = valid_q;
    bundle_d = bundle_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_xfer) begin
      valid_d  = 1'b1;
      bundle_d = dec_bundle;
    end else if (out_xfer) begin
      valid_d = 1'b0;
    end
  end

  // Output slot registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      bundle_q <= '0;
    end else begin
      valid_q  <= valid_d;
      bundle_q <= bundle_d;
    end
  end

  assign idu_valid       = valid_q;
  assign dec_pc          = bundle_q.pc;
  assign dec_rd          = bundle_q.rd;
  assign dec_rs1         = bundle_q.rs1;
  assign dec_rs2         = bundle_q.rs2;
  assign dec_imm         = bundle_q.imm;
  assign dec_funct3      = bundle_q.funct3;
  assign dec_alu_op      = bundle_q.alu_op;
  assign dec_alu_src_imm = bundle_q.alu_src_imm;
  assign dec_wen         = bundle_q.wen;
  assign dec_mem_ren     = bundle_q.mem_ren;
  assign dec_mem_wen     = bundle_q.mem_wen;
  assign dec_branch      = bundle_q.branch;
  assign dec_jal         = bundle_q.jal;
  assign dec_jalr        = bundle_q.jalr;
  assign dec_lui         = bundle_q.lui;
  assign dec_auipc       = bundle_q.auipc;
  assign dec_ebreak      = bundle_q.ebreak;
  assign dec_illegal     = bundle_q.illegal;

endmodule

// File: tb/tb_idu_decode.sv
// Bench for idu_decode: directed scenarios followed by randomized traffic against a
// reference decoder and handshake model.
module tb_idu_decode;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        wen;
    logic        mem_ren;
    logic        mem_wen;
    logic        branch;
    logic        jal;
    logic        jalr;
    logic        lui;
    logic        auipc;
    logic        ebreak;
    logic        illegal;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic        ifu_valid;
  logic [63:0] ifu_data;
  logic        idu_ready;
  logic        flush;
  logic        idu_valid;
  logic        exu_ready;
  logic [31:0] dec_pc;
  logic [4:0]  dec_rd;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic [31:0] dec_imm;
  logic [2:0]  dec_funct3;
  logic [3:0]  dec_alu_op;
  logic        dec_alu_src_imm;
  logic        dec_wen;
  logic        dec_mem_ren;
  logic        dec_mem_wen;
  logic        dec_branch;
  logic        dec_jal;
  logic        dec_jalr;
  logic        dec_lui;
  logic        dec_auipc;
  logic        dec_ebreak;
  logic        dec_illegal;

  int checks = 0;
  int errors = 0;

  idu_decode #(.WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .ifu_valid       (ifu_valid),
    .ifu_data        (ifu_data),
    .idu_ready       (idu_ready),
    .flush           (flush),
    .idu_valid       (idu_valid),
    .exu_ready       (exu_ready),
    .dec_pc          (dec_pc),
    .dec_rd          (dec_rd),
    .dec_rs1         (dec_rs1),
    .dec_rs2         (dec_rs2),
    .dec_imm         (dec_imm),
    .dec_funct3      (dec_funct3),
    .dec_alu_op      (dec_alu_op),
    .dec_alu_src_imm (dec_alu_src_imm),
    .dec_wen         (dec_wen),
    .dec_mem_ren     (dec_mem_ren),
    .dec_mem_wen     (dec_mem_wen),
    .dec_branch      (dec_branch),
    .dec_jal         (dec_jal),
    .dec_jalr        (dec_jalr),
    .dec_lui         (dec_lui),
    .dec_auipc       (dec_auipc),
    .dec_ebreak      (dec_ebreak),
    .dec_illegal     (dec_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bundle_t dut_bundle();
    bundle_t b;
    b.pc = dec_pc; b.rd = dec_rd; b.rs1 = dec_rs1; b.rs2 = dec_rs2;
    b.imm = dec_imm; b.funct3 = dec_funct3; b.alu_op = dec_alu_op;
    b.alu_src_imm = dec_alu_src_imm; b.wen = dec_wen; b.mem_ren = dec_mem_ren;
    b.mem_wen = dec_mem_wen; b.branch = dec_branch; b.jal = dec_jal; b.jalr = dec_jalr;
    b.lui = dec_lui; b.auipc = dec_auipc; b.ebreak = dec_ebreak; b.illegal = dec_illegal;
    return b;
  endfunction

  // Reference decoder written from the ISA rules with plain arithmetic.
  function automatic bundle_t model(input logic [31:0] inst, input logic [31:0] pc);
    bundle_t     b;
    int unsigned f3;
    int unsigned f7;
    int unsigned alu_tab [8];
    logic [31:0] sgn;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic        writes;
    logic        ill;
    alu_tab = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = 32'(inst[14:12]);
    f7 = 32'(inst[31:25]);
    sgn = inst[31] ? 32'hFFFF_FFFF : 32'h0;
    imm_i = 32'($signed(inst) >>> 20);
    imm_s = (32'($signed(inst) >>> 25) << 5) | 32'(inst[11:7]);
    imm_b = (sgn << 12) | (32'(inst[7]) << 11) | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
    imm_u = inst & 32'hFFFF_F000;
    imm_j = (sgn << 20) | (32'(inst[19:12]) << 12) | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
    b = '0;
    b.pc = pc; b.rd = inst[11:7]; b.rs1 = inst[19:15]; b.rs2 = inst[24:20];
    b.funct3 = inst[14:12];
    writes = 1'b0;
    ill = 1'b0;
    case (inst[6:0])
      7'h33: begin
        writes = 1'b1;
        b.alu_op = 4'(alu_tab[f3]);
        if (inst[30] && f3 == 0) b.alu_op = 4'd1;
        if (inst[30] && f3 == 5) b.alu_op = 4'd7;
        ill = !(f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)));
      end
      7'h13: begin
        writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_i;
        b.alu_op = 4'(alu_tab[f3]);
        if (inst[30] && f3 == 5) b.alu_op = 4'd7;
        ill = (f3 == 1 && f7 != 0) || (f3 == 5 && !(f7 == 0 || f7 == 32));
      end
      7'h03: begin
        writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_i; b.mem_ren = 1'b1;
        ill = (f3 == 3 || f3 == 6 || f3 == 7);
      end
      7'h23: begin
        b.alu_src_imm = 1'b1; b.imm = imm_s; b.mem_wen = 1'b1;
        ill = (f3 >= 3);
      end
      7'h63: begin
        b.imm = imm_b; b.branch = 1'b1;
        ill = (f3 == 2 || f3 == 3);
      end
      7'h6F: begin writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_j; b.jal = 1'b1; end
      7'h67: begin
        writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_i; b.jalr = 1'b1;
        ill = (f3 != 0);
      end
      7'h37: begin writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_u; b.lui = 1'b1; end
      7'h17: begin writes = 1'b1; b.alu_src_imm = 1'b1; b.imm = imm_u; b.auipc = 1'b1; end
      7'h0F: b.imm = imm_i;
      7'h73: begin
        b.imm = imm_i;
        b.ebreak = (inst == 32'h0010_0073);
        ill = !b.ebreak;
      end
      default: ill = 1'b1;
    endcase
    b.illegal = ill;
    if (ill || b.ebreak) begin
      writes = 1'b0; b.mem_ren = 1'b0; b.mem_wen = 1'b0;
      b.branch = 1'b0; b.jal = 1'b0; b.jalr = 1'b0;
    end
    b.wen = writes && (inst[11:7] != 5'd0);
    return b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    logic [6:0]  ops [11];
    int          k;
    ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    r = $urandom;
    k = int'($urandom_range(0, 13));
    if (k < 11) r[6:0] = ops[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    if ($urandom_range(0, 15) == 0) r = 32'h0010_0073;
    return r;
  endfunction

  task automatic offer(input logic [31:0] i, input logic [31:0] p);
    ifu_valid = 1'b1;
    ifu_data  = {i, p};
  endtask

  bundle_t     b;
  bundle_t     m_b;
  logic        m_valid;
  logic        exp_ready;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  initial begin
    rst = 1'b0; ifu_valid = 1'b0; ifu_data = '0; flush = 1'b0; exu_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_valid", 128'(idu_valid), 128'(0));
    chk("reset_bundle", 128'(dut_bundle()), 128'(0));
    chk("reset_ready", 128'(idu_ready), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", 128'(idu_ready), 128'(1));

    // addi -> beq -> lui back to back
    exu_ready = 1'b1;
    offer(32'h0050_0093, 32'h8000_0000);
    @(negedge clk);
    b = dut_bundle();
    chk("addi_valid", 128'(idu_valid), 128'(1));
    chk("addi_rd", 128'(b.rd), 128'(1));
    chk("addi_rs1", 128'(b.rs1), 128'(0));
    chk("addi_imm", 128'(b.imm), 128'(5));
    chk("addi_alu", 128'(b.alu_op), 128'(0));
    chk("addi_src_imm", 128'(b.alu_src_imm), 128'(1));
    chk("addi_wen", 128'(b.wen), 128'(1));
    chk("addi_pc", 128'(b.pc), 128'(32'h8000_0000));
    chk("addi_full", 128'(b), 128'(model(32'h0050_0093, 32'h8000_0000)));
    offer(32'hFE20_8EE3, 32'h8000_0004);
    @(negedge clk);
    b = dut_bundle();
    chk("beq_valid", 128'(idu_valid), 128'(1));
    chk("beq_branch", 128'(b.branch), 128'(1));
    chk("beq_imm", 128'(b.imm), 128'(32'hFFFF_FFFC));
    chk("beq_funct3", 128'(b.funct3), 128'(0));
    chk("beq_wen", 128'(b.wen), 128'(0));
    chk("beq_full", 128'(b), 128'(model(32'hFE20_8EE3, 32'h8000_0004)));
    offer(32'h1234_52B7, 32'h8000_0008);
    @(negedge clk);
    b = dut_bundle();
    chk("lui_valid", 128'(idu_valid), 128'(1));
    chk("lui_imm", 128'(b.imm), 128'(32'h1234_5000));
    chk("lui_flag", 128'(b.lui), 128'(1));
    chk("lui_rd", 128'(b.rd), 128'(5));
    chk("lui_full", 128'(b), 128'(model(32'h1234_52B7, 32'h8000_0008)));
    ifu_valid = 1'b0;
    @(negedge clk);
    chk("drain_valid", 128'(idu_valid), 128'(0));

    // Back-pressure hold and bubble-free release
    offer(32'h00A0_0193, 32'h0000_0100);
    @(negedge clk);
    chk("bp_a_valid", 128'(idu_valid), 128'(1));
    exu_ready = 1'b0;
    offer(32'h0020_8233, 32'h0000_0104);
    #1;
    chk("bp_ready_low", 128'(idu_ready), 128'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", 128'(idu_valid), 128'(1));
      chk("bp_hold_bundle", 128'(dut_bundle()), 128'(model(32'h00A0_0193, 32'h0000_0100)));
      chk("bp_hold_ready", 128'(idu_ready), 128'(0));
    end
    exu_ready = 1'b1;
    #1;
    chk("bp_release_ready", 128'(idu_ready), 128'(1));
    @(negedge clk);
    chk("bp_b_valid", 128'(idu_valid), 128'(1));
    chk("bp_b_bundle", 128'(dut_bundle()), 128'(model(32'h0020_8233, 32'h0000_0104)));
    ifu_valid = 1'b0;
    @(negedge clk);
    chk("bp_drain_valid", 128'(idu_valid), 128'(0));

    // ebreak, all-ones illegal, compressed-looking illegal, addi x0
    offer(32'h0010_0073, 32'h0000_0200);
    @(negedge clk);
    b = dut_bundle();
    chk("ebreak_flag", 128'(b.ebreak), 128'(1));
    chk("ebreak_illegal", 128'(b.illegal), 128'(0));
    chk("ebreak_full", 128'(b), 128'(model(32'h0010_0073, 32'h0000_0200)));
    offer(32'hFFFF_FFFF, 32'h0000_0204);
    @(negedge clk);
    b = dut_bundle();
    chk("ones_illegal", 128'(b.illegal), 128'(1));
    chk("ones_side_fx", 128'({b.wen, b.mem_ren, b.mem_wen, b.branch, b.jal, b.jalr}), 128'(0));
    chk("ones_full", 128'(b), 128'(model(32'hFFFF_FFFF, 32'h0000_0204)));
    offer(32'h0050_0091, 32'h0000_0208);
    @(negedge clk);
    chk("lowbits_illegal", 128'(dec_illegal), 128'(1));
    offer(32'h0000_0013, 32'h0000_020C);
    @(negedge clk);
    chk("nop_wen", 128'(dec_wen), 128'(0));
    chk("nop_full", 128'(dut_bundle()), 128'(model(32'h0000_0013, 32'h0000_020C)));
    ifu_valid = 1'b0;
    @(negedge clk);

    // Flush with a held bundle and a packet on offer
    offer(32'h00A0_0193, 32'h0000_0300);
    @(negedge clk);
    chk("fl_c_valid", 128'(idu_valid), 128'(1));
    exu_ready = 1'b0;
    offer(32'h4020_8233, 32'h0000_0304);
    flush = 1'b1;
    #1;
    chk("fl_ready", 128'(idu_ready), 128'(0));
    @(negedge clk);
    chk("fl_valid_cleared", 128'(idu_valid), 128'(0));
    flush = 1'b0;
    #1;
    chk("fl_ready_after", 128'(idu_ready), 128'(1));
    @(negedge clk);
    chk("fl_d_valid", 128'(idu_valid), 128'(1));
    chk("fl_d_sub", 128'(dec_alu_op), 128'(1));
    chk("fl_d_bundle", 128'(dut_bundle()), 128'(model(32'h4020_8233, 32'h0000_0304)));

    // Asynchronous reset mid-cycle with a bundle held
    ifu_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async_valid", 128'(idu_valid), 128'(0));
    chk("async_bundle", 128'(dut_bundle()), 128'(0));
    chk("async_ready", 128'(idu_ready), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_release_ready", 128'(idu_ready), 128'(1));
    chk("async_release_valid", 128'(idu_valid), 128'(0));

    // Randomized traffic against the reference model
    m_valid = 1'b0;
    m_b = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      chk("rnd_valid", 128'(idu_valid), 128'(m_valid));
      if (m_valid) chk("rnd_bundle", 128'(dut_bundle()), 128'(m_b));
      r_inst    = gen_inst();
      r_pc      = $urandom & 32'hFFFF_FFFC;
      ifu_valid = ($urandom_range(0, 3) != 0);
      ifu_data  = {r_inst, r_pc};
      exu_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      #1;
      exp_ready = !flush && (!m_valid || exu_ready);
      chk("rnd_ready", 128'(idu_ready), 128'(exp_ready));
      if (flush) begin
        m_valid = 1'b0;
      end else if (ifu_valid && exp_ready) begin
        m_b     = model(r_inst, r_pc);
        m_valid = 1'b1;
      end else if (m_valid && exu_ready) begin
        m_valid = 1'b0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idu_decode.md
# idu_decode

Instruction decode stage placed directly downstream of the instruction fetch unit. Accepts a 64-bit fetch packet {inst, pc} over a valid/ready handshake and decodes one RV32I instruction per transfer. Registers the decoded control/operand bundle and presents it to the execute stage over a second valid/ready handshake. Provides one-entry buffering, a flush, and illegal-instruction detection.

## Interface
- WIDTH, 32, PC and data width; only 32 is supported.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state immediately.
- ifu_valid  input  1  fetch packet valid.
- ifu_data  input  64  fetch packet; [63:32] holds the instruction and [31:0] holds the PC.
- idu_ready  output  1  decode stage can accept a packet; combinational.
- flush  input  1  drop the buffered instruction and block acceptance this cycle.
- idu_valid  output  1  decoded bundle valid.
- exu_ready  input  1  execute stage accepts the bundle.
- dec_pc  output  32  PC of the instruction.
- dec_rd, dec_rs1, dec_rs2  output  5 each  register indices: inst[11:7], inst[19:15], inst[24:20].
- dec_imm  output  32  sign-extended immediate.
- dec_funct3  output  3  inst[14:12]; used for branch condition and memory size.
- dec_alu_op  output  4  ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
- dec_alu_src_imm  output  1  ALU operand B is dec_imm rather than rs2.
- dec_wen  output  1  register write-back.
- dec_mem_ren, dec_mem_wen  output  1 each  load or store.
- dec_branch, dec_jal, dec_jalr, dec_lui, dec_auipc  output  1 each  instruction class flags.
- dec_ebreak, dec_illegal  output  1 each  system/exception flags.

## Operation
- Input transfer occurs when ifu_valid && idu_ready.
- idu_ready = !flush && (!idu_valid || exu_ready). This lets a new packet load in the same cycle the old bundle drains.
- Output transfer occurs when idu_valid && exu_ready.
- Output register update rule, evaluated at each rising edge:
  - flush: idu_valid <= 0.
  - Otherwise, on input transfer: capture the decoded bundle and set idu_valid <= 1.
  - Otherwise, on output transfer: idu_valid <= 0.
  - Otherwise: hold.
- All dec_* outputs are stable whenever idu_valid && !exu_ready.
- Immediate formats:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25], inst[11:7]}).
  - B: sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U: {inst[31:12], 12'b0}.
  - J: sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R-type: dec_imm = 0.
- Supported opcodes: OP, OP-IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC-MEM, SYSTEM.
  - MISC-MEM (FENCE) decodes as a no-op: all flags 0.
- ALU op selection:
  - funct7[5] selects SUB/SRA for OP.
  - funct7[5] selects SRA for OP-IMM shifts.
  - Loads, stores, JAL, JALR, AUIPC and LUI use ADD.
- dec_wen is 1 for OP, OP-IMM, LOAD, JAL, JALR, LUI and AUIPC. It is forced to 0 when rd == 0.
- dec_illegal is set for any of the following:
  - inst[1:0] != 2'b11.
  - Unknown opcode.
  - BRANCH with funct3 of 2 or 3.
  - LOAD with funct3 of 3, 6 or 7.
  - STORE with funct3 >= 3.
  - JALR with funct3 != 0.
  - OP with funct7 other than 0x00/0x20, or 0x20 with funct3 other than 0/5.
  - Shift-immediate with a bad funct7.
  - SYSTEM other than exactly 0x00100073 (which sets dec_ebreak).
- When dec_illegal or dec_ebreak is set, all side-effect flags are 0: wen, mem_ren, mem_wen, branch, jal, jalr.
- An illegal instruction still completes both handshakes normally.

## Timing
- Reset (rst low, asynchronous): idu_valid = 0 and every dec_* output = 0. After release, idu_ready = 1.
- Latency: a packet accepted at edge N appears with idu_valid = 1 after edge N. Throughput is one instruction per cycle while exu_ready = 1.
- Simultaneous input and output transfer: the bundle is replaced, idu_valid stays 1, and there is no bubble.
- Flush while idu_valid = 1 and exu_ready = 1 in the same cycle: the output transfer counts as completed downstream, and idu_valid = 0 next cycle.
- Reset asserted mid-operation: the buffered instruction is discarded. idu_ready goes low only through the reset path and rises after release.

## Test plan
- addi x1,x0,5 (0x00500093) at pc 0x80000000, exu_ready = 1 -> next cycle idu_valid = 1, rd = 1, rs1 = 0, dec_imm = 5, alu_op = ADD, alu_src_imm = 1, dec_wen = 1, dec_pc = 0x80000000.
- beq x1,x2,-4 (0xFE208EE3) -> dec_branch = 1, dec_imm = 0xFFFFFFFC, dec_funct3 = 0, dec_wen = 0. Then lui x5,0x12345 (0x123452B7) -> dec_imm = 0x12345000, dec_lui = 1, rd = 5.
- Back-pressure: exu_ready = 0 with a bundle held and a second packet offered -> idu_ready = 0 and outputs unchanged for 3 cycles. Release exu_ready -> the second bundle appears on the next cycle with no bubble.
- ebreak (0x00100073) -> dec_ebreak = 1, dec_illegal = 0. Then 0xFFFFFFFF -> dec_illegal = 1 with all side-effect flags 0. Then addi x0,x0,0 -> dec_wen = 0.
- Flush with a held bundle and ifu_valid = 1 -> idu_ready = 0 that cycle and idu_valid = 0 next cycle. The following cycle's packet is accepted normally.
- Assert rst low asynchronously mid-cycle while idu_valid = 1 -> idu_valid = 0 and dec_* = 0 immediately, before the next edge.
